// File: rtl/forward_unit_pkg.sv
// Shared types for the decode-stage forwarding producer: register/word widths,
// the forwarding bundle seen by the operand selector, and one shadow-pipeline slot.
package forward_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [REG_AW-1:0] creg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef struct packed {
    creg_addr_t waE;
    logic       regwriteE;
    word_t      resultE;
    creg_addr_t waM;
    logic       regwriteM;
    word_t      resultM;
    creg_addr_t waW;
    logic       regwriteW;
    word_t      resultW;
  } forward_data_t;

  typedef struct packed {
    logic       valid;
    creg_addr_t wa;
    logic       regwrite;
    logic       is_load;
  } fwd_slot_t;

  localparam fwd_slot_t SLOT_EMPTY = '0;

  // x0 is hardwired, so a write to it must never be advertised as a forward source.
  function automatic fwd_slot_t slot_sanitize(input fwd_slot_t s);
    fwd_slot_t r;
    r          = s;
    r.regwrite = s.regwrite & (s.wa != '0);
    return r;
  endfunction

endpackage

// File: rtl/fwd_slot.sv
// One shadow-pipeline slot: clears on reset, loads a sanitized entry when
// load_i is high, otherwise holds.
module fwd_slot
  import forward_unit_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      load_i,
  input  fwd_slot_t slot_i,
  output fwd_slot_t slot_o
);

  fwd_slot_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (load_i) slot_d = slot_sanitize(slot_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) slot_q <= SLOT_EMPTY;
    else         slot_q <= slot_d;
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/forward_unit.sv
// Producer side of decode-stage forwarding: shadows dest/regwrite/load of the
// E, M and W stages, builds the forwarding bundle, and raises load-use stalls.
module forward_unit
  import forward_unit_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  creg_addr_t    d_wa,
  input  logic          d_regwrite,
  input  logic          d_is_load,
  input  creg_addr_t    d_ra1,
  input  creg_addr_t    d_ra2,
  input  logic          d_uses1,
  input  logic          d_uses2,
  input  logic          flush,
  input  logic          m_busy,
  input  word_t         resultE,
  input  word_t         resultM,
  input  word_t         resultW,
  output forward_data_t forward,
  output logic          stall_d,
  output logic          bubble_e
);

  fwd_slot_t slot_e, slot_m, slot_w;
  fwd_slot_t e_in;
  logic      advance;
  logic      hit1, hit2, lu;

  assign advance = ~m_busy;

  fwd_slot u_slot_e (.clk_i(clk), .reset_i(reset), .load_i(advance), .slot_i(e_in),   .slot_o(slot_e));
  fwd_slot u_slot_m (.clk_i(clk), .reset_i(reset), .load_i(advance), .slot_i(slot_e), .slot_o(slot_m));
  fwd_slot u_slot_w (.clk_i(clk), .reset_i(reset), .load_i(advance), .slot_i(slot_m), .slot_o(slot_w));

  // A load in E only has its address; a dependent decode op must wait one cycle.
  assign hit1 = d_uses1 & (d_ra1 == slot_e.wa);
  assign hit2 = d_uses2 & (d_ra2 == slot_e.wa);
  assign lu   = d_valid & slot_e.valid & slot_e.is_load & slot_e.regwrite & (hit1 | hit2);

  // Reset gating keeps stale slot contents from leaking during the reset cycle.
  assign stall_d  = ~reset & (m_busy | lu);
  assign bubble_e = reset | (~m_busy & (lu | flush | ~d_valid));

  always_comb begin
    e_in = SLOT_EMPTY;
    if (!bubble_e) begin
      e_in.valid    = d_valid;
      e_in.wa       = d_wa;
      e_in.regwrite = d_regwrite;
      e_in.is_load  = d_is_load;
    end
  end

  always_comb begin
    forward           = '0;
    forward.resultE   = resultE;
    forward.resultM   = resultM;
    forward.resultW   = resultW;
    if (!reset) begin
      forward.waE       = slot_e.wa;
      forward.regwriteE = slot_e.valid & slot_e.regwrite & ~slot_e.is_load;
      forward.waM       = slot_m.wa;
      forward.regwriteM = slot_m.valid & slot_m.regwrite;
      forward.waW       = slot_w.wa;
      forward.regwriteW = slot_w.valid & slot_w.regwrite;
    end
  end

endmodule

// File: tb/tb_forward_unit.sv
// Directed scenarios plus randomized traffic for forward_unit, checked against
// a three-entry list model of the E/M/W instructions.
module tb_forward_unit;
  import forward_unit_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_valid, d_regwrite, d_is_load, d_uses1, d_uses2;
  creg_addr_t    d_wa, d_ra1, d_ra2;
  logic          flush, m_busy;
  word_t         resultE, resultM, resultW;
  forward_data_t forward;
  logic          stall_d, bubble_e;

  int n_cmp = 0;
  int n_err = 0;

  // Model: index 0 = E, 1 = M, 2 = W.
  bit          mv[3];
  int unsigned mwa[3];
  bit          mrw[3];
  bit          mld[3];

  forward_unit dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_wa(d_wa), .d_regwrite(d_regwrite),
    .d_is_load(d_is_load), .d_ra1(d_ra1), .d_ra2(d_ra2), .d_uses1(d_uses1), .d_uses2(d_uses2),
    .flush(flush), .m_busy(m_busy), .resultE(resultE), .resultM(resultM), .resultW(resultW),
    .forward(forward), .stall_d(stall_d), .bubble_e(bubble_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_lu();
    bit dep;
    dep = (d_uses1 && (int'(d_ra1) == mwa[0])) || (d_uses2 && (int'(d_ra2) == mwa[0]));
    return d_valid && mv[0] && mld[0] && mrw[0] && dep;
  endfunction

  task automatic check_all();
    bit rst, lu, exp_stall, exp_bub;
    rst       = reset;
    lu        = model_lu();
    exp_stall = rst ? 1'b0 : (m_busy || lu);
    exp_bub   = rst ? 1'b1 : (!m_busy && (lu || flush || !d_valid));
    check("stall_d",   stall_d,           exp_stall);
    check("bubble_e",  bubble_e,          exp_bub);
    check("waE",       forward.waE,       rst ? 0 : mwa[0]);
    check("regwriteE", forward.regwriteE, rst ? 0 : (mv[0] && mrw[0] && !mld[0]));
    check("waM",       forward.waM,       rst ? 0 : mwa[1]);
    check("regwriteM", forward.regwriteM, rst ? 0 : (mv[1] && mrw[1]));
    check("waW",       forward.waW,       rst ? 0 : mwa[2]);
    check("regwriteW", forward.regwriteW, rst ? 0 : (mv[2] && mrw[2]));
    check("resultE",   forward.resultE,   resultE);
    check("resultM",   forward.resultM,   resultM);
    check("resultW",   forward.resultW,   resultW);
  endtask

  task automatic model_update();
    bit bub;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        mv[i] = 0; mwa[i] = 0; mrw[i] = 0; mld[i] = 0;
      end
    end else if (!m_busy) begin
      bub = model_lu() || flush || !d_valid;
      for (int i = 2; i > 0; i--) begin
        mv[i] = mv[i-1]; mwa[i] = mwa[i-1]; mrw[i] = mrw[i-1]; mld[i] = mld[i-1];
      end
      if (bub) begin
        mv[0] = 0; mwa[0] = 0; mrw[0] = 0; mld[0] = 0;
      end else begin
        mv[0]  = 1;
        mwa[0] = int'(d_wa);
        mrw[0] = d_regwrite && (d_wa != 0);
        mld[0] = d_is_load;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
    resultE = $urandom;
    resultM = $urandom;
    resultW = $urandom;
  endtask

  task automatic set_d(input bit v, input int wa, input bit rw, input bit ld,
                       input int ra1, input int ra2, input bit u1, input bit u2);
    d_valid    = v;
    d_wa       = creg_addr_t'(wa);
    d_regwrite = rw;
    d_is_load  = ld;
    d_ra1      = creg_addr_t'(ra1);
    d_ra2      = creg_addr_t'(ra2);
    d_uses1    = u1;
    d_uses2    = u2;
  endtask

  task automatic idle();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0; mwa[i] = 0; mrw[i] = 0; mld[i] = 0;
    end
    reset = 1; flush = 0; m_busy = 0;
    resultE = 32'h1111_0001; resultM = 32'h2222_0002; resultW = 32'h3333_0003;
    idle();
    tick(); tick();
    reset = 0;

    // ADD x5 walks E -> M -> W
    set_d(1, 5, 1, 0, 1, 2, 1, 1);
    tick();
    idle();
    #1 check("add5_waE", forward.waE, 5);
    check("add5_rwE", forward.regwriteE, 1);
    tick();
    #1 check("add5_waM", forward.waM, 5);
    tick();
    #1 check("add5_waW", forward.waW, 5);
    check("add5_rwW", forward.regwriteW, 1);
    tick();

    // load-use: LD x6 then ADD x7,x6,x1
    set_d(1, 6, 1, 1, 2, 3, 1, 1);
    tick();
    set_d(1, 7, 1, 0, 6, 1, 1, 1);
    #1 check("lu_stall", stall_d, 1);
    check("lu_bubble", bubble_e, 1);
    check("lu_rwE", forward.regwriteE, 0);
    tick();
    #1 check("lu_after_waM", forward.waM, 6);
    check("lu_after_rwM", forward.regwriteM, 1);
    check("lu_after_stall", stall_d, 0);
    tick();

    // LD x6 then ADDI x7,x0,1: no dependency
    set_d(1, 6, 1, 1, 2, 3, 1, 1);
    tick();
    set_d(1, 7, 1, 0, 0, 6, 1, 0);
    #1 check("addi_nostall", stall_d, 0);
    tick();

    // x8 held in M across a 3-cycle m_busy
    set_d(1, 8, 1, 0, 1, 2, 1, 1);
    tick();
    idle();
    tick();
    m_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("busy_stall", stall_d, 1);
      check("busy_waM", forward.waM, 8);
      tick();
    end
    m_busy = 0;
    tick();
    #1 check("release_waW", forward.waW, 8);
    check("release_rwW", forward.regwriteW, 1);

    // flush with ADD x9 in D
    set_d(1, 9, 1, 0, 1, 2, 1, 1);
    flush = 1;
    tick();
    flush = 0;
    idle();
    #1 check("flush_rwE", forward.regwriteE, 0);
    check("flush_waE", forward.waE, 0);

    // ADDI x0 never advertises a write
    set_d(1, 0, 1, 0, 1, 0, 1, 0);
    tick();
    idle();
    #1 check("x0_rwE", forward.regwriteE, 0);
    tick();

    // reset mid-pipeline and mid-freeze
    set_d(1, 10, 1, 0, 1, 2, 1, 1);
    tick();
    set_d(1, 11, 1, 1, 1, 2, 1, 1);
    tick();
    m_busy = 1; reset = 1;
    #1 check("rst_stall", stall_d, 0);
    check("rst_bubble", bubble_e, 1);
    check("rst_rwM", forward.regwriteM, 0);
    tick();
    reset = 0; m_busy = 0;
    idle();
    #1 check("post_rst_rwE", forward.regwriteE, 0);
    check("post_rst_rwM", forward.regwriteM, 0);
    check("post_rst_rwW", forward.regwriteW, 0);
    tick();

    // randomized traffic on a narrow register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      set_d($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 4) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      flush  = ($urandom_range(0, 9) == 0);
      m_busy = ($urandom_range(0, 6) == 0);
      reset  = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 0; m_busy = 0; flush = 0;
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/forward_unit.md
# forward_unit

Producer side of the decode-stage forwarding interface. Tracks the destination register, write-enable and load flag of every instruction in the Execute, Memory and Writeback stages in a shadow pipeline. Pairs each slot with the datapath result of that stage to drive `forward_data_t` to the decode-stage operand/immediate selector. Also generates the load-use stall and the decode-to-execute bubble, and freezes its shadow pipeline while the data bus is busy.

## Interface
Parameters: none (widths come from `common`/`pipes`).

- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high; clears all slots
- `d_valid`  in  1  decode stage holds a real instruction
- `d_wa`  in  `creg_addr_t`  decode destination register
- `d_regwrite`  in  1  decode instruction writes `d_wa`
- `d_is_load`  in  1  decode instruction is a load (LD)
- `d_ra1`, `d_ra2`  in  `creg_addr_t`  decode source registers
- `d_uses1`, `d_uses2`  in  1  source actually read (e.g. `d_uses2`=0 for ADDI/LUI)
- `flush`  in  1  kill the decode instruction; it must not enter E
- `m_busy`  in  1  data-memory access outstanding; whole back end frozen
- `resultE`, `resultM`, `resultW`  in  `word_t`  current stage results from the datapath
- `forward`  out  `forward_data_t`  {waE, regwriteE, resultE, waM, regwriteM, resultM, waW, regwriteW, resultW}
- `stall_d`  out  1  hold F and D this cycle
- `bubble_e`  out  1  the E slot loads a bubble at the next edge

## Operation
- Slot contents: `valid`, `wa`, `regwrite`, `is_load`. On capture, `regwrite` is forced to 0 when `wa`==0.
- Advance (edge, `m_busy`=0): W<-M, M<-E. E<-decode when `bubble_e`=0, else E<-bubble (all fields 0).
- Freeze (`m_busy`=1): E, M and W all hold. `stall_d`=1 and `bubble_e`=0.
- Load-use hazard `lu`: `d_valid` & E.valid & E.is_load & E.regwrite & ((`d_uses1` & `d_ra1`==E.wa) | (`d_uses2` & `d_ra2`==E.wa)).
- `stall_d` = `m_busy` | `lu`.
- `bubble_e` = ~`m_busy` & (`lu` | `flush` | ~`d_valid`).
- `flush` and `lu` together: a single bubble; `stall_d`=1, so the flushed instruction is held in D and the fetch redirect is the front end's responsibility.
- `forward` outputs:
  - `regwriteE` = E.valid & E.regwrite & ~E.is_load, because an E-stage load carries an address, not data.
  - `regwriteM` = M.valid & M.regwrite.
  - `regwriteW` = W.valid & W.regwrite.
  - `wa*` are the slot `wa` values.
  - `result*` are the inputs passed straight through.
- The consumer applies priority E > M > W. This block guarantees that the youngest valid writer in each slot is reported.

## Timing
- Slot update latency: 1 cycle. All outputs are combinational from slot state and current inputs, with no extra register.
- Reset (edge with `reset`=1): all slots invalid/zero. While `reset` is high, `stall_d`=0, `bubble_e`=1, and all `regwrite*`/`wa*`=0.
- Load-use: exactly one stall cycle when the load is in E and the consumer is in D. On the following cycle the load is in M and `regwriteM`=1, so the data forwards from `resultM`.
- Multi-cycle `m_busy`: the freeze lasts for every high cycle. Release takes effect at the first edge with `m_busy`=0.
- `m_busy` during `lu`: freeze wins. `lu` is re-evaluated after release.
- Reset mid-freeze or mid-stall: reset dominates; slots clear and no stale `regwrite*` survives.

## Structure
- `pipes` package: add `fwd_slot_t` {valid, wa, regwrite, is_load}. `forward_data_t` stays in `pipes`, unchanged.
- One sub-module, `fwd_slot`: a reset/hold/load register of `fwd_slot_t`, instantiated three times (E, M, W).

## Test plan
- ADD x5 in D, advanced 1 cycle -> `waE`=5, `regwriteE`=1. 2 cycles -> `waM`=5, `regwriteM`=1. 3 cycles -> `waW`=5, `regwriteW`=1.
- LD x6 in E, D=ADD x7,x6,x1 -> `stall_d`=1, `bubble_e`=1, `regwriteE`=0. Next cycle: `waM`=6, `regwriteM`=1, `stall_d`=0.
- LD x6 in E, D=ADDI x7,x0,1 (`d_uses2`=0, ra1=0) -> no stall.
- `m_busy` high 3 cycles with x8 in M -> slots unchanged, `stall_d`=1 throughout. On release, x8 moves to W.
- `flush`=1 with ADD x9 in D -> E becomes a bubble next cycle, `regwriteE`=0.
- ADDI x0 in D -> `regwriteE`=0 after capture. Assert `reset` mid-pipeline -> all `regwrite*`=0 next cycle.
